// File: rtl/mem_arbiter_pkg.sv
// cpu_types_pkg: memory-system types shared by the caches, the RAM model and mem_arbiter.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} arb_state_t;
    localparam int ARB_STARVE_LIMIT = 4;
endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// arb_starve_ctr: counts dcache wins while icache waits; o_starved forces one icache grant.
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_starved
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && !o_starved)
            r_cnt <= r_cnt + 1'b1;
    end
    assign o_starved = (r_cnt == W'(LIMIT));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between icache and dcache, dcache first.
// ARB_FAIR_EN: after STARVE_LIMIT dcache completions with icache waiting, icache wins once.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate
);
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    arb_state_t r_state, w_next;
    logic w_dreq, w_dgnt, w_ignt, w_dfin, w_ifin, w_starved;

    assign w_dreq = dREN || dWEN;
    assign w_dgnt = (r_state == DGRANT);
    assign w_ignt = (r_state == IGRANT);
    // A completion needs the requester still asking; a dropped request is an abort.
    assign w_dfin = w_dgnt && w_dreq && (ramstate == ACCESS);
    assign w_ifin = w_ignt && iREN && (ramstate == ACCESS);

`ifdef ARB_FAIR_EN
    arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .i_clk    (CLK),
        .i_rst_n  (nRST),
        .i_inc    (w_dfin && iREN),
        .i_clr    (w_ifin || !iREN),
        .o_starved(w_starved)
    );
`else
    assign w_starved = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE)   ? ((iREN && (w_starved || !w_dreq)) ? IGRANT : w_dreq ? DGRANT : IDLE)
               : (r_state == DGRANT) ? ((w_dfin || !w_dreq) ? IDLE : DGRANT)
               : (r_state == IGRANT) ? ((w_ifin || !iREN) ? IDLE : IGRANT)
               : IDLE;
    end

    always_comb begin
        ramREN   = (w_dgnt && dREN) || (w_ignt && iREN);
        ramWEN   = w_dgnt && dWEN;
        ramaddr  = w_dgnt ? daddr : w_ignt ? iaddr : '0;
        ramstore = w_dgnt ? dstore : '0;
        dwait    = !w_dfin;
        iwait    = !w_ifin;
        dload    = ramload;
        iload    = ramload;
    end
endmodule
